kmap_sweep_ctrl: RTL and testbench
==================================

# kmap_sweep_ctrl

Sequencer that exhaustively exercises a 4-input combinational Karnaugh-map function block (inputs a, b, c, d; output dout) and checks it against an expected truth table. On a start request it drives all 16 input combinations in ascending order, captures dout into a 16-bit truth-table register, and counts mismatches against a 16-bit expected mask. It sits beside the kmap function block as its on-chip self-check controller.

## Interface
- RAND_CYCLES, 32: number of random vectors applied after the exhaustive sweep (only with KMAP_SWEEP_RANDOM_EN); range 1..255.
- LFSR_SEED, 16'hACE1: non-zero seed loaded into the LFSR on each accepted start.

- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- start  in  1  run request; accepted only in IDLE.
- exp_mask  in  16  expected truth table; bit i is the expected dout for {a,b,c,d}=i. Latched on start acceptance.
- dout  in  1  output of the function block under control.
- a, b, c, d  out  1 each  vector to the function block; {a,b,c,d} = index, a is MSB.
- busy  out  1  high in SWEEP and RAND.
- done  out  1  one-cycle pulse when a run completes.
- pass  out  1  err_count==0 at completion; held until the next accepted start.
- truth_table  out  16  captured dout per index.
- err_count  out  8  mismatch count, saturates at 255.
- first_err_idx  out  4  index of the first mismatch.
- first_err_valid  out  1  at least one mismatch recorded.

## Operation
- States: IDLE, SWEEP, RAND (only with macro), DONE.
- IDLE: a..d=0, busy=0. start=1 -> latch exp_mask, clear truth_table, err_count, first_err_*, pass; load vec=0, LFSR=LFSR_SEED; go to SWEEP.
- SWEEP: drive vec. On each edge, sample dout: truth_table[vec]<=dout; if dout!=exp_q[vec], increment err_count (saturating); if first_err_valid=0, set first_err_idx=vec and first_err_valid=1. vec increments; after vec=15 is sampled -> RAND (if enabled) else DONE.
- RAND: drive LFSR[3:0]; compare as in SWEEP but do not write truth_table; LFSR advances every edge (16-bit Galois, taps 16'hB400). After RAND_CYCLES compares -> DONE.
- DONE: done=1, busy=0, a..d=0, pass<=(err_count==0); next edge -> IDLE. start is ignored in DONE.
- start while busy: ignored, no effect on the current run.
- start held high: a new run is accepted on the first IDLE cycle.
- Reset: every output 0 (including pass, truth_table, err_count, first_err_*), state IDLE, LFSR=LFSR_SEED. Reset mid-run aborts immediately; no done pulse.

## Timing
- Edge E0 accepts start; between E0 and E1: busy=1, {a,b,c,d}=0.
- Edge Ek (k=1..16) samples dout for index k-1. dout is purely combinational from a..d; no extra pipeline stage.
- Without macro: done=1 in the cycle after E16 (17 cycles after the acceptance edge); IDLE after E17.
- With macro: random compares at E17..E(16+RAND_CYCLES); done follows in the next cycle.
- Result outputs are stable from the done cycle until the next accepted start or reset.

## Configuration
- KMAP_SWEEP_RANDOM_EN defined: RAND state, LFSR, and RAND_CYCLES random compares are compiled in.
- Not defined: there is no RAND state and no LFSR; SWEEP goes directly to DONE; RAND_CYCLES and LFSR_SEED are unused.

## Test plan
- Function stub matching exp_mask=16'h6A3C; start pulse -> done 17 cycles after acceptance, truth_table=16'h6A3C, err_count=0, pass=1, first_err_valid=0.
- dout tied 0, exp_mask=16'h8001 -> err_count=2, first_err_idx=0, first_err_valid=1, pass=0, truth_table=16'h0000.
- dout tied 0, exp_mask=16'h8000 -> err_count=1, first_err_idx=15; a second start during busy is ignored (exactly one done pulse).
- resetn=0 for one cycle while vec=8 -> next cycle: all outputs 0, IDLE, no done pulse; a following start completes a normal run.
- start held high for 40 cycles -> first run accepted at E0, second run accepted on the IDLE cycle after the first done; exactly two done pulses, spaced 18 cycles apart.
- KMAP_SWEEP_RANDOM_EN defined, RAND_CYCLES=4, matching stub -> done 21 cycles after acceptance; the four RAND vectors equal LFSR[3:0] from seed 16'hACE1 stepped with taps 16'hB400; err_count=0.

Source files
------------

// File: rtl/kmap_sweep_ctrl.sv
// kmap_sweep_ctrl: drives all 16 {a,b,c,d} vectors into a K-map block, captures dout and counts mismatches.
// Latency: done pulses 17 cycles after start acceptance (+RAND_CYCLES when KMAP_SWEEP_RANDOM_EN is defined).
// Backpressure: none; start is only honoured in IDLE and ignored while busy or done.
module kmap_sweep_ctrl #(
    parameter int unsigned RAND_CYCLES = 32,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [15:0] exp_mask,
    input  logic        dout,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] truth_table,
    output logic [7:0]  err_count,
    output logic [3:0]  first_err_idx,
    output logic        first_err_valid
);

    if (RAND_CYCLES < 1 || RAND_CYCLES > 255) begin : g_bad_rand_cycles
        $error("RAND_CYCLES must be in 1..255");
    end
    if (LFSR_SEED == 16'h0000) begin : g_bad_seed
        $error("LFSR_SEED must be non-zero");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_RAND  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state_q;
    logic [3:0]  vec_q;
    logic [15:0] exp_q;
    logic [15:0] tt_q;
    logic [7:0]  err_q;
    logic [3:0]  fidx_q;
    logic        fvld_q;
    logic        pass_q;
    logic        busy_q;
    logic        done_q;

    logic        mism;
    logic [7:0]  err_nxt;

    // dout is combinational from the vector currently on a..d, so compare against that index.
    assign mism    = (dout != exp_q[vec_q]);
    assign err_nxt = (mism && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;

`ifdef KMAP_SWEEP_RANDOM_EN
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_nxt;
    logic [7:0]  rcnt_q;

    assign lfsr_nxt = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            vec_q   <= 4'd0;
            exp_q   <= 16'h0000;
            tt_q    <= 16'h0000;
            err_q   <= 8'd0;
            fidx_q  <= 4'd0;
            fvld_q  <= 1'b0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef KMAP_SWEEP_RANDOM_EN
            lfsr_q  <= LFSR_SEED;
            rcnt_q  <= 8'd0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        exp_q   <= exp_mask;
                        tt_q    <= 16'h0000;
                        err_q   <= 8'd0;
                        fidx_q  <= 4'd0;
                        fvld_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        vec_q   <= 4'd0;
                        busy_q  <= 1'b1;
                        state_q <= S_SWEEP;
`ifdef KMAP_SWEEP_RANDOM_EN
                        lfsr_q  <= LFSR_SEED;
`endif
                    end
                end

                S_SWEEP: begin
                    tt_q[vec_q] <= dout;
                    err_q       <= err_nxt;
                    if (mism && !fvld_q) begin
                        fidx_q <= vec_q;
                        fvld_q <= 1'b1;
                    end
                    if (vec_q == 4'd15) begin
`ifdef KMAP_SWEEP_RANDOM_EN
                        // LFSR holds the seed through the sweep; its low nibble is the first random vector.
                        vec_q   <= lfsr_q[3:0];
                        rcnt_q  <= 8'd0;
                        state_q <= S_RAND;
`else
                        vec_q   <= 4'd0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_nxt == 8'd0);
                        state_q <= S_DONE;
`endif
                    end else begin
                        vec_q <= vec_q + 4'd1;
                    end
                end

`ifdef KMAP_SWEEP_RANDOM_EN
                S_RAND: begin
                    err_q  <= err_nxt;
                    if (mism && !fvld_q) begin
                        fidx_q <= vec_q;
                        fvld_q <= 1'b1;
                    end
                    lfsr_q <= lfsr_nxt;
                    rcnt_q <= rcnt_q + 8'd1;
                    if (rcnt_q == 8'(RAND_CYCLES - 1)) begin
                        vec_q   <= 4'd0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_nxt == 8'd0);
                        state_q <= S_DONE;
                    end else begin
                        vec_q <= lfsr_nxt[3:0];
                    end
                end
`endif

                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    vec_q   <= 4'd0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign {a, b, c, d}    = vec_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign truth_table     = tt_q;
    assign err_count       = err_q;
    assign first_err_idx   = fidx_q;
    assign first_err_valid = fvld_q;

endmodule

// File: tb/tb_kmap_sweep_ctrl.sv
// Directed bench for kmap_sweep_ctrl: a behavioural K-map stub answers a..d from a programmable truth table.
module tb_kmap_sweep_ctrl;

`ifdef KMAP_SWEEP_RANDOM_EN
    localparam int RC  = 4;
`else
    localparam int RC  = 0;
`endif
    localparam int LAT = 17 + RC;
    localparam int WIN = (RC == 0) ? 40 : 2 * LAT + 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [15:0] exp_mask = 16'h0000;
    logic [15:0] stub = 16'h0000;
    logic        dout;
    logic        a, b, c, d, busy, done, pass, first_err_valid;
    logic [15:0] truth_table;
    logic [7:0]  err_count;
    logic [3:0]  first_err_idx;

    int total = 0;
    int bad   = 0;

    // Seed 16'hACE1 stepped with Galois taps 16'hB400: ACE1 -> E270 -> 7138 -> 389C.
    logic [3:0] rvec [4] = '{4'h1, 4'h0, 4'h8, 4'hC};

    assign dout = stub[{a, b, c, d}];

    always #5 clk = ~clk;

    kmap_sweep_ctrl #(.RAND_CYCLES(4), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .resetn(resetn), .start(start), .exp_mask(exp_mask), .dout(dout),
        .a(a), .b(b), .c(c), .d(d), .busy(busy), .done(done), .pass(pass),
        .truth_table(truth_table), .err_count(err_count),
        .first_err_idx(first_err_idx), .first_err_valid(first_err_valid)
    );

    typedef struct {
        logic [15:0] stub;
        logic [15:0] exp;
        logic [15:0] tt;
        int          err;
        logic [3:0]  fidx;
        logic        fvld;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic int rand_err(input logic [15:0] s, input logic [15:0] e);
        int r = 0;
        for (int i = 0; i < RC; i++)
            if (s[rvec[i]] != e[rvec[i]]) r++;
        return r;
    endfunction

    function automatic int all_outs();
        return int'({a, b, c, d, busy, done, pass, first_err_valid, first_err_idx})
             | int'(truth_table) | int'(err_count);
    endfunction

    task automatic run_one(input vec_t v, input string tag);
        int          lat = -1;
        int          ndone = 0;
        logic        seq_ok = 1'b1;
        logic [15:0] tt_c = 16'h0;
        logic [7:0]  err_c = 8'h0;
        logic [3:0]  fidx_c = 4'h0;
        logic        fvld_c = 1'b0;
        logic        pass_c = 1'b0;
        int          exp_err;
        stub     = v.stub;
        exp_mask = v.exp;
        exp_err  = v.err + rand_err(v.stub, v.exp);
        start    = 1'b1;
        for (int n = 1; n <= LAT + 3; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (n == 5) start = 1'b1;
            if (n == 6) start = 1'b0;
            if (n <= 16 && ({a, b, c, d} != 4'(n - 1) || !busy)) seq_ok = 1'b0;
            if (n > 16 && n <= 16 + RC && {a, b, c, d} != rvec[n - 17]) seq_ok = 1'b0;
            if (done) begin
                ndone++;
                if (lat < 0) begin
                    lat = n;
                    tt_c = truth_table; err_c = err_count; fidx_c = first_err_idx;
                    fvld_c = first_err_valid; pass_c = pass;
                    if (busy || {a, b, c, d} != 4'h0) seq_ok = 1'b0;
                end
            end
            if (n > LAT && busy) seq_ok = 1'b0;
        end
        chk({tag, "_latency"}, lat, LAT);
        chk({tag, "_ndone"}, ndone, 1);
        chk({tag, "_vecseq"}, int'(seq_ok), 1);
        chk({tag, "_tt"}, int'(tt_c), int'(v.tt));
        chk({tag, "_err"}, int'(err_c), exp_err);
        chk({tag, "_fvld"}, int'(fvld_c), int'(v.fvld));
        chk({tag, "_fidx"}, int'(fidx_c), int'(v.fidx));
        chk({tag, "_pass"}, int'(pass_c), int'(exp_err == 0));
        chk({tag, "_tt_hold"}, int'(truth_table), int'(v.tt));
    endtask

    initial begin
        int d1, d2, cnt;
        tbl[0] = '{stub: 16'h6A3C, exp: 16'h6A3C, tt: 16'h6A3C, err: 0,  fidx: 4'h0, fvld: 1'b0};
        tbl[1] = '{stub: 16'h0000, exp: 16'h8001, tt: 16'h0000, err: 2,  fidx: 4'h0, fvld: 1'b1};
        tbl[2] = '{stub: 16'h0000, exp: 16'h8000, tt: 16'h0000, err: 1,  fidx: 4'hF, fvld: 1'b1};
        tbl[3] = '{stub: 16'hFFFF, exp: 16'h0000, tt: 16'hFFFF, err: 16, fidx: 4'h0, fvld: 1'b1};
        tbl[4] = '{stub: 16'h00FF, exp: 16'h0F0F, tt: 16'h00FF, err: 8,  fidx: 4'h4, fvld: 1'b1};

        @(negedge clk);
        @(negedge clk);
        chk("reset_outs", all_outs(), 0);
        resetn = 1'b1;
        @(negedge clk);
        chk("idle_outs", all_outs(), 0);

        for (int i = 0; i < 5; i++) run_one(tbl[i], $sformatf("v%0d", i));

        // Abort a run mid-sweep with a one-cycle reset.
        stub = 16'h6A3C; exp_mask = 16'h0000; start = 1'b1;
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("rst_mid_vec", int'({a, b, c, d}), 8);
        chk("rst_mid_err_before", int'(err_count), 4);
        resetn = 1'b0;
        @(negedge clk);
        chk("rst_mid_outs", all_outs(), 0);
        resetn = 1'b1;
        cnt = 0;
        for (int n = 0; n < LAT + 8; n++) begin
            @(negedge clk);
            if (done || busy) cnt++;
        end
        chk("rst_mid_no_done", cnt, 0);
        run_one(tbl[0], "after_rst");

        // start held high: back-to-back runs, second accepted on the first IDLE cycle.
        stub = 16'h6A3C; exp_mask = 16'h6A3C; start = 1'b1;
        cnt = 0; d1 = -1; d2 = -1;
        for (int n = 1; n <= WIN; n++) begin
            @(negedge clk);
            if (done) begin
                cnt++;
                if (d1 < 0) d1 = n; else if (d2 < 0) d2 = n;
            end
        end
        start = 1'b0;
        chk("held_ndone", cnt, 2);
        chk("held_first", d1, LAT);
        chk("held_spacing", d2 - d1, LAT + 1);

        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("final_idle", all_outs(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
